// File: rtl/pipelined_cpu.sv
// pipelined_cpu: 5-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with forwarding,
// load-use stall and EX-resolved branches. Define CPU_TRACE_EN to print every WB register write.

module imem #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic [31:0] addr_i,
    output logic [31:0] instr_o
);
    localparam int AW = $clog2(IMEM_DEPTH);

    // Contents are preloaded externally; the core only ever reads them.
    logic [31:0] rom_memory [0:IMEM_DEPTH-1];
    logic        unused_addr;

    assign instr_o     = rom_memory[addr_i[AW+1:2]];
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
endmodule

module if_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i)   pc_d = target_i;
        else if (!hold_i) pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    imem #(.IMEM_DEPTH(IMEM_DEPTH)) imem_inst (.addr_i(pc_q), .instr_o(instr_o));
    assign pc_o = pc_q;
endmodule

module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] register_memory [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) register_memory[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            register_memory[wa_i] <= wd_i;
        end
    end

    // Same-cycle WB bypass so ID never reads a stale value.
    always_comb begin
        rd1_o = register_memory[ra1_i];
        rd2_o = register_memory[ra2_i];
        if (we_i && wa_i == ra1_i) rd1_o = wd_i;
        if (we_i && wa_i == ra2_i) rd2_o = wd_i;
        if (ra1_i == 5'd0) rd1_o = '0;
        if (ra2_i == 5'd0) rd2_o = '0;
    end
endmodule

module pipelined_cpu #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [3:0] {
        A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND, A_PASSB
    } alu_e;

    typedef struct packed {
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       src_a_pc;
        logic       src_b_imm;
        alu_e       alu;
        logic [2:0] f3;
    } ctrl_t;

    function automatic alu_e alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? A_SUB : A_ADD;
            3'b001:  alu_of = A_SLL;
            3'b010:  alu_of = A_SLT;
            3'b011:  alu_of = A_SLTU;
            3'b100:  alu_of = A_XOR;
            3'b101:  alu_of = alt ? A_SRA : A_SRL;
            3'b110:  alu_of = A_OR;
            default: alu_of = A_AND;
        endcase
    endfunction

    logic        stall, load_use, redirect;
    logic [31:0] target;
    logic [31:0] if_pc, if_instr;

    logic        ifid_vld_q;
    logic [31:0] ifid_pc_q, ifid_instr_q;

    logic        idex_vld_q;
    ctrl_t       idex_ctrl_q;
    logic [31:0] idex_pc_q, idex_imm_q, idex_a_q, idex_b_q;
    logic [4:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;

    logic        exmem_vld_q, exmem_we_q, exmem_mwe_q, exmem_mre_q;
    logic [4:0]  exmem_rd_q;
    logic [31:0] exmem_res_q, exmem_sdata_q;

    logic        memwb_vld_q, memwb_we_q;
    logic [4:0]  memwb_rd_q;
    logic [31:0] memwb_res_q;

    logic [31:0] dmem [0:DMEM_DEPTH-1];

    if_stage #(.IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(RESET_PC)) if_stage_inst (
        .clk(clk), .rst(rst), .hold_i(stall), .redirect_i(redirect), .target_i(target),
        .pc_o(if_pc), .instr_o(if_instr)
    );

    // ---------------- ID ----------------
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_a, id_b, dec_imm, imm_i;
    ctrl_t       dec;
    logic        wb_we;

    assign opc    = ifid_instr_q[6:0];
    assign id_rd  = ifid_instr_q[11:7];
    assign f3     = ifid_instr_q[14:12];
    assign id_rs1 = ifid_instr_q[19:15];
    assign id_rs2 = ifid_instr_q[24:20];
    assign f7     = ifid_instr_q[31:25];
    assign imm_i  = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};

    always_comb begin
        dec     = '0;
        dec_imm = imm_i;
        dec.f3  = f3;
        dec.alu = A_ADD;
        case (opc)
            7'b0110111: begin
                dec.reg_we = 1'b1; dec.src_b_imm = 1'b1; dec.alu = A_PASSB;
                dec_imm = {ifid_instr_q[31:12], 12'b0};
            end
            7'b0010111: begin
                dec.reg_we = 1'b1; dec.src_a_pc = 1'b1; dec.src_b_imm = 1'b1;
                dec_imm = {ifid_instr_q[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.reg_we = 1'b1; dec.jal = 1'b1;
                dec_imm = {{12{ifid_instr_q[31]}}, ifid_instr_q[19:12], ifid_instr_q[20],
                           ifid_instr_q[30:21], 1'b0};
            end
            7'b1100111: if (f3 == 3'b000) begin dec.reg_we = 1'b1; dec.jalr = 1'b1; end
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
                dec.branch = 1'b1;
                dec_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[7], ifid_instr_q[30:25],
                           ifid_instr_q[11:8], 1'b0};
            end
            7'b0000011: if (f3 == 3'b010) begin
                dec.reg_we = 1'b1; dec.mem_re = 1'b1; dec.src_b_imm = 1'b1;
            end
            7'b0100011: if (f3 == 3'b010) begin
                dec.mem_we = 1'b1; dec.src_b_imm = 1'b1;
                dec_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
            end
            7'b0010011: begin
                // Shift-immediates carry their funct7 in imm[11:5]; anything else there is a NOP.
                if ((f3 != 3'b001 && f3 != 3'b101) || f7 == 7'b0 ||
                    (f3 == 3'b101 && f7 == 7'b0100000)) begin
                    dec.reg_we = 1'b1; dec.src_b_imm = 1'b1;
                    dec.alu = alu_of(f3, f3 == 3'b101 && f7[5]);
                end
            end
            7'b0110011: begin
                if (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec.reg_we = 1'b1;
                    dec.alu = alu_of(f3, f7[5]);
                end
            end
            default: ;
        endcase
    end

    reg_file reg_file_inst (
        .clk(clk), .rst(rst), .ra1_i(id_rs1), .ra2_i(id_rs2), .we_i(wb_we),
        .wa_i(memwb_rd_q), .wd_i(memwb_res_q), .rd1_o(id_a), .rd2_o(id_b)
    );

    // ---------------- hazard unit ----------------
    assign load_use = idex_vld_q && idex_ctrl_q.mem_re && idex_rd_q != 5'd0 && ifid_vld_q &&
                      (idex_rd_q == id_rs1 || idex_rd_q == id_rs2);
    assign stall    = load_use && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_vld_q <= 1'b0; ifid_pc_q <= '0; ifid_instr_q <= '0;
        end else if (redirect) begin
            ifid_vld_q <= 1'b0;
        end else if (!stall) begin
            ifid_vld_q <= 1'b1; ifid_pc_q <= if_pc; ifid_instr_q <= if_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_vld_q <= 1'b0; idex_ctrl_q <= '0; idex_pc_q <= '0; idex_imm_q <= '0;
            idex_a_q <= '0; idex_b_q <= '0; idex_rs1_q <= '0; idex_rs2_q <= '0; idex_rd_q <= '0;
        end else begin
            idex_vld_q  <= ifid_vld_q && !redirect && !stall;
            idex_ctrl_q <= (ifid_vld_q && !redirect && !stall) ? dec : '0;
            idex_pc_q   <= ifid_pc_q;  idex_imm_q <= dec_imm;
            idex_a_q    <= id_a;       idex_b_q   <= id_b;
            idex_rs1_q  <= id_rs1;     idex_rs2_q <= id_rs2;   idex_rd_q <= id_rd;
        end
    end

    // ---------------- EX + forwarding unit ----------------
    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_y, ex_res;
    logic        take;

    always_comb begin
        fwd_a = idex_a_q;
        fwd_b = idex_b_q;
        if (memwb_vld_q && memwb_we_q && memwb_rd_q != 5'd0) begin
            if (memwb_rd_q == idex_rs1_q) fwd_a = memwb_res_q;
            if (memwb_rd_q == idex_rs2_q) fwd_b = memwb_res_q;
        end
        if (exmem_vld_q && exmem_we_q && exmem_rd_q != 5'd0) begin
            if (exmem_rd_q == idex_rs1_q) fwd_a = exmem_res_q;
            if (exmem_rd_q == idex_rs2_q) fwd_b = exmem_res_q;
        end
    end

    assign op_a = idex_ctrl_q.src_a_pc  ? idex_pc_q  : fwd_a;
    assign op_b = idex_ctrl_q.src_b_imm ? idex_imm_q : fwd_b;

    always_comb begin
        case (idex_ctrl_q.alu)
            A_ADD:   alu_y = op_a + op_b;
            A_SUB:   alu_y = op_a - op_b;
            A_SLL:   alu_y = op_a << op_b[4:0];
            A_SLT:   alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
            A_SLTU:  alu_y = {31'b0, op_a < op_b};
            A_XOR:   alu_y = op_a ^ op_b;
            A_SRL:   alu_y = op_a >> op_b[4:0];
            A_SRA:   alu_y = $signed(op_a) >>> op_b[4:0];
            A_OR:    alu_y = op_a | op_b;
            A_AND:   alu_y = op_a & op_b;
            default: alu_y = op_b;
        endcase
        case (idex_ctrl_q.f3)
            3'b000:  take = fwd_a == fwd_b;
            3'b001:  take = fwd_a != fwd_b;
            3'b100:  take = $signed(fwd_a) <  $signed(fwd_b);
            3'b101:  take = $signed(fwd_a) >= $signed(fwd_b);
            3'b110:  take = fwd_a <  fwd_b;
            3'b111:  take = fwd_a >= fwd_b;
            default: take = 1'b0;
        endcase
    end

    assign redirect = idex_vld_q && (idex_ctrl_q.jal || idex_ctrl_q.jalr ||
                                     (idex_ctrl_q.branch && take));
    assign target   = idex_ctrl_q.jalr ? ((fwd_a + idex_imm_q) & ~32'd1) : idex_pc_q + idex_imm_q;
    assign ex_res   = (idex_ctrl_q.jal || idex_ctrl_q.jalr) ? idex_pc_q + 32'd4 : alu_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_vld_q <= 1'b0; exmem_we_q <= 1'b0; exmem_mwe_q <= 1'b0; exmem_mre_q <= 1'b0;
            exmem_rd_q <= '0; exmem_res_q <= '0; exmem_sdata_q <= '0;
        end else begin
            exmem_vld_q   <= idex_vld_q;
            exmem_we_q    <= idex_vld_q && idex_ctrl_q.reg_we;
            exmem_mwe_q   <= idex_vld_q && idex_ctrl_q.mem_we;
            exmem_mre_q   <= idex_vld_q && idex_ctrl_q.mem_re;
            exmem_rd_q    <= idex_rd_q;
            exmem_res_q   <= ex_res;
            exmem_sdata_q <= fwd_b;
        end
    end

    // ---------------- MEM ----------------
    always_ff @(posedge clk) begin
        if (exmem_vld_q && exmem_mwe_q) dmem[exmem_res_q[DAW+1:2]] <= exmem_sdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_vld_q <= 1'b0; memwb_we_q <= 1'b0; memwb_rd_q <= '0; memwb_res_q <= '0;
        end else begin
            memwb_vld_q <= exmem_vld_q;
            memwb_we_q  <= exmem_vld_q && exmem_we_q;
            memwb_rd_q  <= exmem_rd_q;
            memwb_res_q <= exmem_mre_q ? dmem[exmem_res_q[DAW+1:2]] : exmem_res_q;
        end
    end

    // ---------------- WB ----------------
    assign wb_we = memwb_vld_q && memwb_we_q;

`ifdef CPU_TRACE_EN
    always @(posedge clk) begin
        if (rst && wb_we && memwb_rd_q != 5'd0)
            $display("WB x%0d = 0x%08h", memwb_rd_q, memwb_res_q);
    end
`else
`endif
endmodule

// File: tb/tb_pipelined_cpu.sv
// Bench for pipelined_cpu: table of programs with expected register results fed through a
// scoreboard queue, plus hand-written reset-state and mid-run reset sequences.
module tb_pipelined_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipelined_cpu dut (.clk(clk), .rst(rst));

    typedef struct packed {
        logic [15:0][31:0] prog;
        logic [4:0]        n;
        logic [7:0]        cycles;
        logic [3:0]        stalls;
        logic [15:0][4:0]  rd;
        logic [15:0][31:0] val;
        logic [4:0]        nexp;
    } vec_t;

    typedef struct packed {
        logic [3:0]  vec;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    exp_t sb [$];
    int   cur;
    int   errors = 0;
    int   checks = 0;
    int   stall_cnt = 0;

    always @(negedge clk) begin
        if (!rst)           stall_cnt = 0;
        else if (dut.stall) stall_cnt++;
    end

    function automatic logic [31:0] itype(input int op, input int f3, input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return itype('h13, 0, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] rtype(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int o);
        return {o[12], o[10:5], rs2[4:0], rs1[4:0], f3[2:0], o[4:1], o[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal_i(input int rd, input int o);
        return {o[20], o[10:1], o[11], o[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] sw_i(input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] utype(input int op, input int rd, input int imm);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    task automatic newv(input int idx, input int cyc, input int st);
        cur = idx;
        vecs[idx] = '0;
        vecs[idx].cycles = cyc[7:0];
        vecs[idx].stalls = st[3:0];
    endtask
    task automatic ins(input logic [31:0] w);
        vecs[cur].prog[vecs[cur].n] = w;
        vecs[cur].n = vecs[cur].n + 5'd1;
    endtask
    task automatic exv(input int r, input logic [31:0] v);
        vecs[cur].rd[vecs[cur].nexp]  = r[4:0];
        vecs[cur].val[vecs[cur].nexp] = v;
        vecs[cur].nexp = vecs[cur].nexp + 5'd1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic load_rom(input int v);
        for (int i = 0; i < 256; i++) dut.if_stage_inst.imem_inst.rom_memory[i] = 32'h0000_0013;
        for (int i = 0; i < int'(vecs[v].n); i++) dut.if_stage_inst.imem_inst.rom_memory[i] = vecs[v].prog[i];
    endtask

    task automatic do_reset(input int v);
        @(negedge clk);
        rst = 1'b0;
        load_rom(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        exp_t e;

        // 0: branches, signed compares, not-taken/taken
        newv(0, 20, 0);
        ins(addi(1, 0, 5));  ins(addi(2, 0, 3));  ins(br(1, 1, 2, 8));  ins(addi(7, 0, 99));
        ins(addi(3, 0, 1));  ins(br(0, 1, 2, 8)); ins(addi(4, 0, 2));   ins(br(4, 2, 1, 8));
        ins(addi(8, 0, 99)); ins(addi(5, 0, 3));  ins(br(5, 2, 1, 8));  ins(addi(6, 0, 4));
        exv(1, 5); exv(2, 3); exv(3, 1); exv(4, 2); exv(5, 3); exv(6, 4); exv(7, 0); exv(8, 0);
        // 1: back-to-back forwarding
        newv(1, 12, 0);
        ins(addi(1, 0, 7)); ins(rtype(0, 0, 2, 1, 1)); ins(rtype('h20, 0, 3, 2, 1));
        exv(1, 7); exv(2, 14); exv(3, 7);
        // 2: store then load-use
        newv(2, 14, 1);
        ins(addi(1, 0, 'h55)); ins(sw_i(1, 0, 0)); ins(itype(3, 2, 2, 0, 0)); ins(addi(3, 2, 1));
        exv(2, 32'h55); exv(3, 32'h56);
        // 3: jal / jalr with flushed fall-through
        newv(3, 30, 0);
        ins(addi(5, 0, 1)); ins(32'h13); ins(32'h13); ins(32'h13);
        ins(jal_i(1, 12)); ins(addi(6, 0, 6)); ins(jal_i(0, 16)); ins(itype('h67, 0, 0, 1, 0));
        ins(addi(8, 0, 99)); ins(addi(9, 0, 99)); ins(addi(10, 0, 10));
        exv(1, 32'h14); exv(5, 1); exv(6, 6); exv(8, 0); exv(9, 0); exv(10, 10);
        // 4: x0 write, signed vs unsigned less-than
        newv(4, 20, 0);
        ins(addi(0, 0, 9)); ins(addi(1, 0, -1)); ins(addi(2, 0, 1)); ins(br(4, 1, 2, 8));
        ins(addi(3, 0, 99)); ins(addi(4, 0, 4)); ins(br(6, 1, 2, 8)); ins(addi(5, 0, 5));
        ins(addi(6, 0, 6));
        exv(0, 0); exv(1, 32'hFFFF_FFFF); exv(3, 0); exv(4, 4); exv(5, 5); exv(6, 6);
        // 5: ALU mix, lui/auipc, illegal encodings as NOP
        newv(5, 30, 0);
        ins(addi(1, 0, -16));            ins(itype('h13, 5, 2, 1, 'h402)); ins(itype('h13, 5, 3, 1, 28));
        ins(itype('h13, 2, 4, 1, 0));    ins(itype('h13, 3, 5, 3, 16));    ins(utype('h37, 6, 'h12345));
        ins(itype('h13, 4, 7, 3, 'hFF)); ins(rtype(0, 7, 8, 1, 3));        ins(rtype(0, 6, 9, 3, 7));
        ins(rtype(0, 1, 10, 3, 3));      ins(rtype('h20, 0, 11, 3, 1));    ins(utype('h17, 12, 1));
        ins(rtype(0, 2, 13, 1, 3));      ins(rtype(0, 3, 14, 1, 3));       ins(32'hFFFF_FFFF);
        ins(rtype('h20, 4, 15, 3, 3));
        exv(2, 32'hFFFF_FFFC); exv(3, 32'hF); exv(4, 1); exv(5, 1); exv(6, 32'h1234_5000);
        exv(7, 32'hF0); exv(8, 0); exv(9, 32'hFF); exv(10, 32'h0007_8000); exv(11, 32'h1F);
        exv(12, 32'h102C); exv(13, 1); exv(14, 0); exv(31, 0); exv(15, 0);

        // Reset state
        load_rom(0);
        @(posedge clk);
        @(negedge clk);
        chk("reset pc",       dut.if_stage_inst.pc_q, 32'h0);
        chk("reset ifid vld", {31'b0, dut.ifid_vld_q},  32'h0);
        chk("reset idex vld", {31'b0, dut.idex_vld_q},  32'h0);
        chk("reset exmem vld",{31'b0, dut.exmem_vld_q}, 32'h0);
        chk("reset memwb vld",{31'b0, dut.memwb_vld_q}, 32'h0);

        for (int t = 0; t < NV; t++) begin
            do_reset(t);
            for (int k = 0; k < int'(vecs[t].nexp); k++)
                sb.push_back('{vec: t[3:0], rd: vecs[t].rd[k], val: vecs[t].val[k]});
            repeat (int'(vecs[t].cycles)) @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("vec%0d x%0d", e.vec, e.rd), dut.reg_file_inst.register_memory[e.rd], e.val);
            end
            chk($sformatf("vec%0d stalls", t), stall_cnt, {28'b0, vecs[t].stalls});
            if (t == 2) chk("vec2 dmem[0]", dut.dmem[0], 32'h55);
        end

        // Mid-run reset: async clear, then restart from RESET_PC
        do_reset(0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("midrun x1 before reset", dut.reg_file_inst.register_memory[1], 32'd5);
        rst = 1'b0;
        #1;
        for (int r = 0; r < 32; r++)
            chk($sformatf("midrun reset x%0d", r), dut.reg_file_inst.register_memory[r], 32'h0);
        chk("midrun reset pc",       dut.if_stage_inst.pc_q, 32'h0);
        chk("midrun reset idex vld", {31'b0, dut.idex_vld_q},  32'h0);
        chk("midrun reset memwb vld",{31'b0, dut.memwb_vld_q}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("restart ifid vld",   {31'b0, dut.ifid_vld_q}, 32'h1);
        chk("restart ifid pc",    dut.ifid_pc_q, 32'h0);
        chk("restart ifid instr", dut.ifid_instr_q, vecs[0].prog[0]);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("restart x3", dut.reg_file_inst.register_memory[3], 32'd1);
        chk("restart x4", dut.reg_file_inst.register_memory[4], 32'd2);
        chk("restart x5", dut.reg_file_inst.register_memory[5], 32'd3);
        chk("restart x6", dut.reg_file_inst.register_memory[6], 32'd4);
        chk("restart x7", dut.reg_file_inst.register_memory[7], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
